// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request ports and unified-memory port of the arbiter
interface mem_port_arbiter_if #(parameter int n = 16);
  logic         i_req;
  logic [n-1:0] i_addr;
  logic         i_gnt;
  logic [n-1:0] i_rdata;
  logic         i_valid;
  logic         d_req;
  logic         d_we;
  logic [n-1:0] d_addr;
  logic [n-1:0] d_wdata;
  logic         d_gnt;
  logic [n-1:0] d_rdata;
  logic         d_valid;
  logic         m_en;
  logic         m_we;
  logic [n-1:0] m_addr;
  logic [n-1:0] m_wdata;
  logic [n-1:0] m_rdata;
  logic         busy;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rdata, i_valid, d_gnt, d_rdata, d_valid, m_en, m_we, m_addr, m_wdata, busy
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rdata, i_valid, d_gnt, d_rdata, d_valid, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate on contention instead of fixed data priority.
module mem_port_arbiter #(
  parameter int n   = 16,
  parameter int LAT = 2
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;
  localparam logic [3:0] cnt_init = 4'(LAT - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic owner, owner_n, wr, wr_n, pick, data_first;
  logic i_gnt, i_gnt_n, d_gnt, d_gnt_n, i_valid, i_valid_n, d_valid, d_valid_n;
  logic m_en, m_en_n, m_we, m_we_n, busy;
  logic [n-1:0] m_addr, m_addr_n, m_wdata, m_wdata_n, i_rdata, i_rdata_n, d_rdata, d_rdata_n;
`ifdef ARB_ROUND_ROBIN_EN
  logic last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last <= FETCH;
    else if (state == ACCESS) last <= owner;
  assign data_first = last == FETCH;
`else
  assign data_first = 1'b1;
`endif
  // data also wins when it is the only requester
  assign pick = bus.d_req && (data_first || !bus.i_req);
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    owner_n   = owner;
    wr_n      = wr;
    i_gnt_n   = 1'b0;
    d_gnt_n   = 1'b0;
    i_valid_n = 1'b0;
    d_valid_n = 1'b0;
    m_en_n    = 1'b0;
    m_we_n    = 1'b0;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;
    i_rdata_n = i_rdata;
    d_rdata_n = d_rdata;
    case (state)
      IDLE: if (bus.i_req || bus.d_req) begin
        state_n   = ACCESS;
        owner_n   = pick;
        wr_n      = pick && bus.d_we;
        m_en_n    = 1'b1;
        m_we_n    = pick && bus.d_we;
        m_addr_n  = pick ? bus.d_addr : bus.i_addr;
        m_wdata_n = pick ? bus.d_wdata : m_wdata;
        i_gnt_n   = !pick;
        d_gnt_n   = pick;
      end
      ACCESS: begin
        state_n = WAIT;
        cnt_n   = cnt_init;
      end
      WAIT: if (cnt == 4'd0) begin
        state_n   = DONE;
        i_rdata_n = (owner == FETCH) ? bus.m_rdata : i_rdata;
        d_rdata_n = (owner == DATA && !wr) ? bus.m_rdata : d_rdata;
        i_valid_n = owner == FETCH;
        d_valid_n = owner == DATA;
      end else cnt_n = cnt - 4'd1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= FETCH;
      wr      <= 1'b0;
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      owner   <= owner_n;
      wr      <= wr_n;
      i_gnt   <= i_gnt_n;
      d_gnt   <= d_gnt_n;
      i_valid <= i_valid_n;
      d_valid <= d_valid_n;
      m_en    <= m_en_n;
      m_we    <= m_we_n;
      m_addr  <= m_addr_n;
      m_wdata <= m_wdata_n;
      i_rdata <= i_rdata_n;
      d_rdata <= d_rdata_n;
      busy    <= state_n != IDLE;
    end
  assign bus.i_gnt   = i_gnt;
  assign bus.d_gnt   = d_gnt;
  assign bus.i_valid = i_valid;
  assign bus.d_valid = d_valid;
  assign bus.m_en    = m_en;
  assign bus.m_we    = m_we;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;
  assign bus.i_rdata = i_rdata;
  assign bus.d_rdata = d_rdata;
  assign bus.busy    = busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, reset abort and handshake corner cases.
module tb_mem_port_arbiter;
  localparam int n = 16;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  int nv, ne;
  mem_port_arbiter_if #(.n(n)) bus ();
  mem_port_arbiter #(.n(n), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] mem [0:255];
  logic [15:0] pipe [1:LAT];
  assign bus.m_rdata = pipe[LAT];
  // memory model: read data appears exactly LAT cycles after m_en, X otherwise
  always @(posedge clk) begin
    if (!reset) begin
      mem[8'h10] <= 16'hbeef;
      mem[8'h30] <= 16'hcafe;
      mem[8'h40] <= 16'h5a5a;
    end else if (bus.m_en && bus.m_we) mem[bus.m_addr[7:0]] <= bus.m_wdata;
    pipe[1] <= bus.m_en ? mem[bus.m_addr[7:0]] : 16'hxxxx;
    for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic is_d, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] exp_rd);
    int t;
    bus.i_req = !is_d; bus.i_addr = addr;
    bus.d_req = is_d; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    tick;
    check("gnt", {bus.i_gnt, bus.d_gnt}, is_d ? 2'b01 : 2'b10);
    check("access", {bus.m_en, bus.m_we, bus.m_addr, bus.busy}, {1'b1, we & is_d, addr, 1'b1});
    if (is_d) check("m_wdata", bus.m_wdata, wdata);
    t = 1;
    while (!(is_d ? bus.d_valid : bus.i_valid) && t < 40) begin
      tick;
      check("busy", bus.busy, 1'b1);
      t++;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("latency", t, LAT + 2);
    check("rdata", is_d ? bus.d_rdata : bus.i_rdata, exp_rd);
    tick;
    check("idle", {bus.busy, bus.i_valid, bus.d_valid, bus.m_en}, 4'b0);
  endtask
  task automatic pair(input logic exp_data_first);
    int td, ti;
    td = 0; ti = 0;
    bus.i_req = 1'b1; bus.i_addr = 16'h30;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h40;
    for (int c = 1; c <= 3 * LAT + 12 && (td == 0 || ti == 0); c++) begin
      tick;
      check("exclusive", {bus.i_gnt & bus.d_gnt, bus.i_valid & bus.d_valid}, 2'b0);
      if (bus.d_valid) begin td = c; bus.d_req = 1'b0; end
      if (bus.i_valid) begin ti = c; bus.i_req = 1'b0; end
    end
    check("first_valid", exp_data_first ? td : ti, LAT + 2);
    check("second_valid", exp_data_first ? ti : td, 2 * LAT + 5);
    check("pair_i_rdata", bus.i_rdata, 16'hcafe);
    check("pair_d_rdata", bus.d_rdata, 16'h5a5a);
    tick;
  endtask
  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0;
    bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    tick;
    tick;
    check("reset_ctl", {bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.m_en, bus.m_we, bus.busy}, 7'b0);
    check("reset_data", {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata}, 64'b0);
    reset = 1'b1;
    tick;
    xact(1'b0, 1'b0, 16'h10, 16'h0, 16'hbeef);
    xact(1'b1, 1'b1, 16'h20, 16'h1234, 16'h0000);
    xact(1'b1, 1'b0, 16'h20, 16'h0, 16'h1234);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h40;
    tick;
    check("drop_gnt", bus.d_gnt, 1'b1);
    bus.d_req = 1'b0;
    nv = 0; ne = 0;
    for (int c = 0; c < LAT + 6; c++) begin
      tick;
      nv += int'(bus.d_valid);
      ne += int'(bus.m_en);
    end
    check("drop_valid_count", nv, 1);
    check("drop_men_count", ne, 0);
    check("drop_rdata", bus.d_rdata, 16'h5a5a);
    bus.i_req = 1'b1; bus.i_addr = 16'h30;
    tick;
    tick;
    #2 reset = 1'b0;
    #1;
    check("abort_ctl", {bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.m_en, bus.m_we, bus.busy}, 7'b0);
    check("abort_data", {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata}, 64'b0);
    bus.i_req = 1'b0;
    tick;
    reset = 1'b1;
    for (int c = 0; c < LAT + 4; c++) begin
      tick;
      check("no_valid_after_abort", {bus.i_valid, bus.d_valid, bus.m_en}, 3'b0);
    end
    xact(1'b0, 1'b0, 16'h10, 16'h0, 16'hbeef);
    pair(1'b1);
    xact(1'b1, 1'b0, 16'h40, 16'h0, 16'h5a5a);
`ifdef ARB_ROUND_ROBIN_EN
    pair(1'b0);
`else
    pair(1'b1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
